// File: rtl/chaotic_pkg.sv
// rtl/chaotic_pkg.sv - shared state codes and binary64 constants for the chaotic iteration sequencer
package chaotic_pkg;

  localparam int DEF_DATA_WIDTH = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // IEEE-754 binary64 seeds and map coefficients shared with the core and benches
  localparam logic [63:0] X0_INIT    = 64'h3FB999999999999A;  // 0.1
  localparam logic [63:0] Y0_INIT    = 64'h0000000000000000;  // 0.0
  localparam logic [63:0] Z0_INIT    = 64'h0000000000000000;  // 0.0
  localparam logic [63:0] COEF_SIGMA = 64'h4024000000000000;  // 10.0
  localparam logic [63:0] COEF_RHO   = 64'h403C000000000000;  // 28.0
  localparam logic [63:0] COEF_BETA  = 64'h4005555555555555;  // 8/3
  localparam logic [63:0] COEF_DT    = 64'h3F847AE147AE147B;  // 0.01

endpackage

// File: rtl/chaotic_sync_fifo.sv
// rtl/chaotic_sync_fifo.sv - first-word-fall-through result FIFO; head reads 0 while empty
module chaotic_sync_fifo #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && !full_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/chaotic_iter_sched.sv
// rtl/chaotic_iter_sched.sv - triggers core iterations, drops burn-in results, buffers the rest
module chaotic_iter_sched
  import chaotic_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [CNT_WIDTH-1:0]  burn_in_i,
  input  logic [CNT_WIDTH-1:0]  num_iter_i,
  output logic                  calcu_ctrl_o,
  input  logic                  core_busy_i,
  input  logic                  n1_valid_i,
  input  logic [DATA_WIDTH-1:0] xn1_i,
  input  logic [DATA_WIDTH-1:0] yn1_i,
  input  logic [DATA_WIDTH-1:0] zn1_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_x_o,
  output logic [DATA_WIDTH-1:0] m_y_o,
  output logic [DATA_WIDTH-1:0] m_z_o,
  output logic                  run_o,
  output logic                  done_o,
  output logic                  err_timeout_o,
  output logic [CNT_WIDTH-1:0]  produced_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]           state_q, state_d;
  logic                 calcu_prev_q;
  logic                 stop_pend_q, stop_pend_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] burn_left_q, burn_left_d;
  logic [CNT_WIDTH-1:0] num_iter_q, num_iter_d;
  logic [CNT_WIDTH-1:0] produced_q, produced_d, produced_inc;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 fire, fifo_push, fifo_full;

  // Free-run can outlast the counter; hold at max instead of wrapping
  assign produced_inc = (produced_q == '1) ? produced_q : produced_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;
    burn_left_d = burn_left_q;
    num_iter_d  = num_iter_q;
    produced_d  = produced_q;
    tmo_d       = tmo_q;
    fire        = 1'b0;
    fifo_push   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          burn_left_d = burn_in_i;
          num_iter_d  = num_iter_i;
          produced_d  = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (!core_busy_i && !calcu_prev_q && (burn_left_q != '0 || !fifo_full)) begin
          fire    = 1'b1;
          tmo_d   = TMO_W'(TIMEOUT_CYC);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (n1_valid_i) begin
          if (burn_left_q != '0) begin
            burn_left_d = burn_left_q - CNT_WIDTH'(1);
          end else begin
            fifo_push  = 1'b1;
            produced_d = produced_inc;
          end
          if (stop_i || stop_pend_q ||
              (fifo_push && num_iter_q != '0 && produced_inc == num_iter_q))
            state_d = S_DONE;
          else
            state_d = S_ISSUE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      calcu_prev_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      err_q        <= 1'b0;
      burn_left_q  <= '0;
      num_iter_q   <= '0;
      produced_q   <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      calcu_prev_q <= fire;
      stop_pend_q  <= stop_pend_d;
      err_q        <= err_d;
      burn_left_q  <= burn_left_d;
      num_iter_q   <= num_iter_d;
      produced_q   <= produced_d;
      tmo_q        <= tmo_d;
    end
  end

  assign calcu_ctrl_o  = fire;
  assign run_o         = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done_o        = (state_q == S_DONE);
  assign err_timeout_o = err_q;
  assign produced_o    = produced_q;

  chaotic_sync_fifo #(
    .WIDTH (3 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  ({xn1_i, yn1_i, zn1_i}),
    .pop_i   (m_ready_i),
    .data_o  ({m_x_o, m_y_o, m_z_o}),
    .valid_o (m_valid_o),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_chaotic_iter_sched.sv
// tb/tb_chaotic_iter_sched.sv - scoreboard bench with a behavioural core model for chaotic_iter_sched
module tb_chaotic_iter_sched;

  localparam int DW  = 64;
  localparam int CW  = 32;
  localparam int TMO = 1023;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [CW-1:0] burn_in = '0, num_iter = '0;
  logic          calcu_ctrl, core_busy, n1_valid;
  logic [DW-1:0] xn1, yn1, zn1, m_x, m_y, m_z;
  logic          m_valid, m_ready = 1'b0;
  logic          run, done, err_timeout;
  logic [CW-1:0] produced;

  int n_cmp = 0, n_bad = 0;
  int pulses = 0, done_cnt = 0;
  int lat = 20;
  bit mute = 0, ready_rand = 0, model_live = 0;
  int cur_burn = 0, cur_num = 0, res_idx = 0, exp_pushed = 0;
  logic [3*DW-1:0] exp_q[$];

  chaotic_iter_sched dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .burn_in_i(burn_in), .num_iter_i(num_iter), .calcu_ctrl_o(calcu_ctrl),
    .core_busy_i(core_busy), .n1_valid_i(n1_valid),
    .xn1_i(xn1), .yn1_i(yn1), .zn1_i(zn1),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_x_o(m_x), .m_y_o(m_y), .m_z_o(m_z),
    .run_o(run), .done_o(done), .err_timeout_o(err_timeout), .produced_o(produced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: results after the first burn_in are kept, up to num_iter (0 = unlimited)
  task automatic model_result(input logic [3*DW-1:0] d);
    res_idx++;
    if (model_live && res_idx > cur_burn && (cur_num == 0 || exp_pushed < cur_num)) begin
      exp_q.push_back(d);
      exp_pushed++;
    end
  endtask

  initial begin
    logic [3*DW-1:0] d;
    core_busy = 1'b0; n1_valid = 1'b0; xn1 = '0; yn1 = '0; zn1 = '0;
    forever begin
      @(negedge clk);
      if (rst_n && calcu_ctrl) begin
        pulses++;
        if (!mute) begin
          @(posedge clk); #1 core_busy = 1'b1;
          repeat (lat) @(posedge clk);
          #1;
          d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
          {xn1, yn1, zn1} = d;
          n1_valid = 1'b1;
          model_result(d);
          @(posedge clk); #1 n1_valid = 1'b0; core_busy = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {m_x, m_y, m_z}, '0);
      else chk("m_data", {m_x, m_y, m_z}, exp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (ready_rand) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input int b, input int n, input bit expect_fire);
    @(posedge clk); #1;
    cur_burn = b; cur_num = n; res_idx = 0; exp_pushed = 0; model_live = 1;
    pulses = 0; done_cnt = 0;
    burn_in = CW'(b); num_iter = CW'(n); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    if (expect_fire) chk("start_to_calcu", 192'(calcu_ctrl), 192'(1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    chk("done_seen", 192'(done), 192'(1));
  endtask

  task automatic wait_pulses(input int k, input int budget);
    int n = 0;
    while (pulses < k && n < budget) begin @(negedge clk); n++; end
    chk("pulse_reached", 192'(pulses >= k), 192'(1));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("queue_drained", 192'(exp_q.size()), 192'(0));
  endtask

  initial begin
    int b, n, cyc;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {m_valid, run, done, err_timeout, calcu_ctrl, produced}, '0);
    chk("rst_head", {m_x, m_y, m_z}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // burn-in 3, deliver 2
    m_ready = 1'b1; lat = 20;
    start_run(3, 2, 1);
    wait_done(500);
    repeat (5) @(negedge clk);
    chk("t1_pulses", 192'(pulses), 192'(5));
    chk("t1_produced", 192'(produced), 192'(2));
    chk("t1_done_once", 192'(done_cnt), 192'(1));
    wait_drain(50);

    // start while in WAIT must not re-latch
    lat = 8;
    start_run(1, 2, 1);
    @(posedge clk); #1 start = 1'b1; burn_in = 5; num_iter = 9;
    @(posedge clk); #1 start = 1'b0;
    wait_done(500);
    repeat (5) @(negedge clk);
    chk("t6_pulses", 192'(pulses), 192'(3));
    chk("t6_produced", 192'(produced), 192'(2));
    wait_drain(50);

    // backpressure: FIFO fills and issue stalls
    m_ready = 1'b0; lat = 5;
    start_run(0, 8, 1);
    repeat (150) @(negedge clk);
    chk("t2_stall_pulses", 192'(pulses), 192'(4));
    chk("t2_stall_run", 192'(run), 192'(1));
    chk("t2_stall_valid", 192'(m_valid), 192'(1));
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(1000);
    repeat (5) @(negedge clk);
    chk("t2_pulses", 192'(pulses), 192'(8));
    chk("t2_produced", 192'(produced), 192'(8));
    wait_drain(50);

    // free-run with stop during the 6th WAIT
    lat = 20;
    start_run(0, 0, 1);
    wait_pulses(6, 1000);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(200);
    repeat (30) @(negedge clk);
    chk("t3_pulses", 192'(pulses), 192'(6));
    chk("t3_produced", 192'(produced), 192'(6));
    chk("t3_done_once", 192'(done_cnt), 192'(1));
    wait_drain(50);

    // randomized runs with random backpressure
    ready_rand = 1;
    for (int r = 0; r < 4; r++) begin
      b = $urandom_range(0, 3); n = $urandom_range(1, 6); lat = $urandom_range(1, 6);
      start_run(b, n, 1);
      wait_done(2000);
      repeat (3) @(negedge clk);
      chk("rand_pulses", 192'(pulses), 192'(b + n));
      chk("rand_produced", 192'(produced), 192'(n));
      wait_drain(200);
    end
    ready_rand = 0; m_ready = 1'b1;

    // core never answers
    mute = 1;
    start_run(0, 1, 1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!err_timeout && cyc < TMO + 50);
    chk("t4_timeout_cycles", 192'(cyc), 192'(TMO + 2));
    chk("t4_done_with_err", 192'(done), 192'(1));
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", 192'(err_timeout), 192'(1));
    mute = 0; lat = 4;
    start_run(0, 1, 1);
    chk("t4_err_cleared", 192'(err_timeout), 192'(0));
    wait_done(200);
    wait_drain(50);

    // reset mid-WAIT with two FIFO entries
    m_ready = 1'b0; lat = 10;
    start_run(0, 5, 1);
    wait_pulses(3, 200);
    repeat (3) @(negedge clk);
    chk("t5_two_entries", 192'(m_valid), 192'(1));
    @(posedge clk); #1 model_live = 0; rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", {m_valid, run, done, err_timeout, calcu_ctrl, produced}, '0);
    chk("t5_rst_head", {m_x, m_y, m_z}, '0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_late_not_pushed", {m_valid, produced}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
